// File: rtl/apb_master_scheduler.sv
// Round-robin scheduler that turns one-cycle master request pulses into APB write transfers.
// Optional ACCESS timeout is enabled with `define APB_TIMEOUT_EN.
module apb_master_scheduler #(
  parameter int NUM_SINKS      = 4,
  parameter int NUM_SOURCES    = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             reset_n,
  input  logic [NUM_SINKS-1:0]             master_valids,
  input  logic [NUM_SINKS*DATA_WIDTH-1:0]  master_data,
  input  logic [NUM_SINKS*ADDR_WIDTH-1:0]  dest_addrs,
  output logic [NUM_SINKS-1:0]             master_busy,
  output logic [NUM_SINKS-1:0]             master_done,
  output logic [NUM_SINKS-1:0]             master_err,
  output logic [NUM_SINKS-1:0]             master_drop,
  output logic [NUM_SOURCES-1:0]           psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic                             pready
);

  localparam int PW = (NUM_SINKS > 1) ? $clog2(NUM_SINKS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                  state_q;
  logic [PW-1:0]           ptr_q;
  logic [PW-1:0]           grant_q;
  logic [NUM_SINKS-1:0]    pending_q;
  logic [DATA_WIDTH-1:0]   data_q [NUM_SINKS];
  logic [ADDR_WIDTH-1:0]   addr_q [NUM_SINKS];
  logic [NUM_SOURCES-1:0]  psel_q;
  logic                    penable_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [NUM_SINKS-1:0]    done_q;
  logic [NUM_SINKS-1:0]    err_q;
  logic [NUM_SINKS-1:0]    drop_q;

  logic [PW-1:0]           pick;
  logic                    has_req;
  logic                    addr_ok;
  logic                    timeout_hit;
  logic [NUM_SINKS-1:0]    complete_d;
  logic [NUM_SINKS-1:0]    err_d;
  logic [NUM_SINKS-1:0]    accept_d;
  logic [NUM_SINKS-1:0]    drop_d;
  logic [NUM_SINKS-1:0]    pending_d;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  assign timeout_hit = (state_q == ACCESS) && !pready && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick    = ptr_q;
    has_req = 1'b0;
    for (int k = 1; k <= NUM_SINKS; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_SINKS;
      if (!has_req && pending_q[idx]) begin
        pick    = PW'(idx);
        has_req = 1'b1;
      end
    end
    addr_ok = int'(addr_q[pick]) < NUM_SOURCES;

    complete_d = '0;
    err_d      = '0;
    if ((state_q == ACCESS) && (pready || timeout_hit)) begin
      complete_d[grant_q] = 1'b1;
      err_d[grant_q]      = !pready;
    end
    if ((state_q == IDLE) && has_req && !addr_ok) begin
      complete_d[pick] = 1'b1;
      err_d[pick]      = 1'b1;
    end

    // A master completing this edge may immediately queue its next request.
    accept_d  = master_valids & (~pending_q | complete_d);
    drop_d    = master_valids & pending_q & ~complete_d;
    pending_d = (pending_q & ~complete_d) | accept_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= PW'(NUM_SINKS - 1);
      grant_q   <= '0;
      pending_q <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
      done_q    <= '0;
      err_q     <= '0;
      drop_q    <= '0;
      // NOTE: the holding registers are small and must read as cleared after reset, so they are reset explicitly.
      for (int i = 0; i < NUM_SINKS; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
`ifdef APB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      done_q    <= complete_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      for (int i = 0; i < NUM_SINKS; i++) begin
        if (accept_d[i]) begin
          data_q[i] <= master_data[i*DATA_WIDTH +: DATA_WIDTH];
          addr_q[i] <= dest_addrs[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end

      case (state_q)
        IDLE: begin
          if (has_req) begin
            if (addr_ok) begin
              grant_q  <= pick;
              psel_q   <= NUM_SOURCES'(1) << addr_q[pick];
              pwdata_q <= data_q[pick];
              state_q  <= SETUP;
            end else begin
              ptr_q <= pick;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_q     <= '0;
`endif
        end
        ACCESS: begin
          if (pready || timeout_hit) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            ptr_q     <= grant_q;
            state_q   <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign master_busy = pending_q;
  assign master_done = done_q;
  assign master_err  = err_q;
  assign master_drop = drop_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = |psel_q;
  assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_master_scheduler.sv
// Scoreboard bench for apb_master_scheduler: batches of requests are scheduled by a
// transaction-level round-robin model; a monitor checks bus cycles and completion pulses.
module tb_apb_master_scheduler;

  localparam int N   = 4;
  localparam int NS  = 8;
  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int TMO = 16;

  logic              pclk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      master_valids;
  logic [N*DW-1:0]   master_data;
  logic [N*AW-1:0]   dest_addrs;
  logic [N-1:0]      master_busy, master_done, master_err, master_drop;
  logic [NS-1:0]     psel;
  logic              penable, pwrite;
  logic [DW-1:0]     pwdata;
  logic              pready;

  apb_master_scheduler #(
    .NUM_SINKS(N), .NUM_SOURCES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .master_valids(master_valids), .master_data(master_data),
    .dest_addrs(dest_addrs), .master_busy(master_busy), .master_done(master_done),
    .master_err(master_err), .master_drop(master_drop), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    bit          err;
  } exp_t;

  typedef enum int {P_ONE, P_RAND, P_STUCK0, P_STALL5} pmode_t;

  exp_t   exp_q[$];
  int     drop_q[$];
  int     ptr_m;
  pmode_t pmode;
  int     passed, total;
  int     psel_cycles, done_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // pready driver: decides the value for the upcoming edge from the current bus phase.
  int acc_n;
  initial begin
    pready = 1'b0;
    acc_n  = 0;
    forever begin
      @(posedge pclk);
      #1;
      if (psel != 0 && penable) acc_n++;
      else acc_n = 0;
      case (pmode)
        P_ONE:    pready = 1'b1;
        P_RAND:   pready = ($urandom_range(0, 3) != 0);
        P_STUCK0: pready = 1'b0;
        P_STALL5: pready = (acc_n > 5);
        default:  pready = 1'b1;
      endcase
    end
  end

  // Monitor: tracks each bus transfer and pops the scoreboard on every done/drop pulse.
  bit            in_xfer, have_last, ready_seen, last_ready;
  logic [NS-1:0] xfer_psel, last_psel;
  logic [DW-1:0] xfer_data, last_data;
  int            acc_cnt, last_acc;
  initial begin
    in_xfer = 0; have_last = 0;
    forever begin
      @(negedge pclk);
      if (!reset_n) begin
        in_xfer = 0; have_last = 0;
        continue;
      end
      if (psel != 0) begin
        psel_cycles++;
        if (!in_xfer) begin
          in_xfer = 1; xfer_psel = psel; xfer_data = pwdata;
          acc_cnt = 0; ready_seen = 0;
          check("setup_penable_low", penable, 1'b0);
          check("pwrite_high", pwrite, 1'b1);
        end else begin
          check("bus_stable", {psel, pwdata}, {xfer_psel, xfer_data});
          check("access_penable", penable, 1'b1);
          if (ready_seen) check("exit_after_pready", 1'b1, 1'b0);
          acc_cnt++;
          if (pready) ready_seen = 1;
        end
      end else if (in_xfer) begin
        in_xfer = 0; have_last = 1;
        last_psel = xfer_psel; last_data = xfer_data;
        last_acc = acc_cnt; last_ready = ready_seen;
        check("idle_bus", {penable, pwrite}, 2'b00);
      end

      if (master_done != 0) begin
        done_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", master_done, '0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_master", master_done, N'(1) << e.idx);
          check("err_flag", master_err, e.err ? (N'(1) << e.idx) : '0);
          check("busy_falls", master_busy[e.idx], 1'b0);
          if (int'(e.addr) < NS) begin
            check("xfer_ended", have_last, 1'b1);
            check("xfer_psel", last_psel, NS'(1) << e.addr);
            check("xfer_pwdata", last_data, e.data);
            if (e.err) check("timeout_len", {last_ready, 32'(last_acc)}, {1'b0, 32'(TMO)});
            else       check("end_on_pready", last_ready, 1'b1);
            if (pmode == P_ONE)    check("access_one_cycle", last_acc, 1);
            if (pmode == P_STALL5) check("access_stall_len", last_acc, 6);
          end else begin
            check("no_bus_for_bad_addr", have_last, 1'b0);
          end
          have_last = 0;
        end
      end else begin
        check("no_stray_err", master_err, '0);
      end

      if (master_drop != 0) begin
        if (drop_q.size() == 0) check("unexpected_drop", master_drop, '0);
        else check("drop_master", master_drop, N'(1) << drop_q.pop_front());
      end
    end
  end

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  function automatic logic [N*AW-1:0] rand_addrs(input bit allow_bad);
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++)
      if (allow_bad && $urandom_range(0, 9) >= 8) a[i*AW +: AW] = AW'($urandom_range(NS, (1 << AW) - 1));
      else a[i*AW +: AW] = AW'($urandom_range(0, NS - 1));
    return a;
  endfunction

  // Issue all masters in mask on one edge; the model orders them round-robin after ptr_m.
  task automatic issue(input logic [N-1:0] mask, input logic [N*DW-1:0] d,
                       input logic [N*AW-1:0] a, input bit do_drop, input bit tmo_err);
    int last;
    last = -1;
    @(negedge pclk);
    master_data   = d;
    dest_addrs    = a;
    master_valids = mask;
    for (int k = 1; k <= N; k++) begin
      int idx;
      exp_t e;
      idx = (ptr_m + k) % N;
      if (mask[idx]) begin
        e.idx  = idx;
        e.data = d[idx*DW +: DW];
        e.addr = a[idx*AW +: AW];
        e.err  = (int'(e.addr) >= NS) || tmo_err;
        exp_q.push_back(e);
        last = idx;
      end
    end
    if (last >= 0) ptr_m = last;
    @(negedge pclk);
    master_valids = '0;
    check("busy_after_capture", master_busy, mask);
    if (do_drop && $countones(mask) >= 2) begin
      master_valids[last] = 1'b1;
      master_data[last*DW +: DW] = ~d[last*DW +: DW];
      drop_q.push_back(last);
      @(negedge pclk);
      master_valids = '0;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 3000; c++) begin
      @(negedge pclk);
      if (exp_q.size() == 0 && drop_q.size() == 0) break;
    end
    check("drain_complete", exp_q.size() + drop_q.size(), 0);
    check("idle_busy", master_busy, '0);
  endtask

  initial begin
    int base_psel, base_done;
    bit seen;
    passed = 0; total = 0; psel_cycles = 0; done_count = 0;
    master_valids = '0; master_data = '0; dest_addrs = '0;
    pmode = P_ONE; ptr_m = N - 1;
    reset_n = 1'b0;
    #22;
    check("reset_outputs", {master_busy, master_done, master_err, master_drop, psel, penable, pwrite, pwdata},
          '0);
    @(negedge pclk);
    reset_n = 1'b1;

    issue(4'b0001, {24'h0, 8'hA5}, {18'h0, 6'd3}, 0, 0);
    drain();
    issue(4'b1111, rand_data(), rand_addrs(0), 0, 0);
    drain();
    issue(4'b0011, rand_data(), rand_addrs(0), 0, 0);
    drain();

    // Master 2 re-requests while waiting behind master 1.
    issue(4'b0001, rand_data(), rand_addrs(0), 0, 0);
    drain();
    issue(4'b0110, rand_data(), rand_addrs(0), 1, 0);
    drain();

    issue(4'b0010, rand_data(), {12'h0, 6'd9, 6'h0}, 0, 0);
    drain();

    pmode = P_STALL5;
    issue(4'b0100, rand_data(), rand_addrs(0), 0, 0);
    drain();

`ifdef APB_TIMEOUT_EN
    pmode = P_STUCK0;
    issue(4'b1000, rand_data(), rand_addrs(0), 0, 1);
    drain();
`endif

    pmode = P_RAND;
    for (int b = 0; b < 40; b++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      issue(m, rand_data(), rand_addrs(1), $urandom_range(0, 1) == 1, 0);
      drain();
    end

    // Reset in the middle of an ACCESS phase with three requests held.
    pmode = P_STUCK0;
    issue(4'b0111, rand_data(), {6'd0, 6'd2, 6'd1, 6'd0}, 0, 0);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge pclk);
      seen = (psel != 0) && penable;
    end
    check("reached_access", seen, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_midxfer", {psel, penable, master_busy, master_done, master_err, master_drop}, '0);
    exp_q.delete(); drop_q.delete(); ptr_m = N - 1;
    @(negedge pclk);
    reset_n = 1'b1;
    pmode = P_ONE;
    base_psel = psel_cycles; base_done = done_count;
    repeat (20) @(negedge pclk);
    check("no_xfer_after_reset", {32'(psel_cycles - base_psel), 32'(done_count - base_done)}, '0);
    check("busy_after_reset", master_busy, '0);

    issue(4'b1111, rand_data(), rand_addrs(0), 0, 0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
